gain_ramp_multi: RTL and testbench

//  Multi-channel audio gain stage for the FM radio back end. Sits between the de-emphasis IIR

---
 rtl/gain_ramp_multi_if.sv | 23 ++
 rtl/gain_ramp_multi.sv | 125 ++++++++++++
 tb/tb_gain_ramp_multi.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gain_ramp_multi_if.sv
// FIFO-side handshake bundle for gain_ramp_multi: FWFT input pop port and output push port.
// The master drives the FIFO status and input frame; the slave is the gain stage.
interface gain_ramp_multi_if #(
    parameter int DATA_SIZE = 32,
    parameter int CHANNELS  = 2
);
    logic                          in_empty;
    logic                          in_rd_en;
    logic [CHANNELS*DATA_SIZE-1:0] in_dout;
    logic                          out_full;
    logic                          out_wr_en;
    logic [CHANNELS*DATA_SIZE-1:0] out_din;

    modport master (
        output in_empty, in_dout, out_full,
        input  in_rd_en, out_wr_en, out_din
    );

    modport slave (
        input  in_empty, in_dout, out_full,
        output in_rd_en, out_wr_en, out_din
    );
endinterface

// File: rtl/gain_ramp_multi.sv
// Multi-channel gain stage: frame x shared Q(BITS) gain, truncate toward zero, saturate.
// The applied gain slews toward the (optionally muted) target by at most RAMP_STEP per frame.
module gain_ramp_multi #(
    parameter int DATA_SIZE = 32,
    parameter int CHANNELS  = 2,
    parameter int BITS      = 10,
    parameter int RAMP_STEP = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    gain_ramp_multi_if.slave            bus,
    input  logic signed [DATA_SIZE-1:0] volume_target,
    input  logic                        mute,
    output logic signed [DATA_SIZE-1:0] volume_cur,
    output logic [15:0]                 sat_count
);
    localparam int FW = CHANNELS * DATA_SIZE;
    localparam int PW = 2 * DATA_SIZE;

    localparam logic signed [PW-1:0] SAT_MAX   = {{(DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN   = {{(DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
    localparam logic signed [PW-1:0] ROUND_ADD = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};
    localparam logic [DATA_SIZE:0]          STEP_MAG = (DATA_SIZE+1)'(RAMP_STEP);
    localparam logic signed [DATA_SIZE-1:0] STEP     = DATA_SIZE'(RAMP_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_WRITE
    } state_t;

    state_t                 state;
    logic [FW-1:0]          x_reg;
    logic [FW-1:0]          out_din_r;
    logic [FW-1:0]          y_next;
    logic                   any_clip;
    logic signed [PW-1:0]   x_ext;
    logic signed [PW-1:0]   v_ext;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   q;

    logic signed [DATA_SIZE-1:0] target_eff;
    logic signed [DATA_SIZE:0]   diff;
    logic [DATA_SIZE:0]          mag;
    logic signed [DATA_SIZE-1:0] vol_next;

    // Handshakes are gated by reset so they drop the instant reset asserts.
    assign bus.in_rd_en  = reset && (state == S_IDLE)  && !bus.in_empty;
    assign bus.out_wr_en = reset && (state == S_WRITE) && !bus.out_full;
    assign bus.out_din   = out_din_r;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        y_next   = '0;
        any_clip = 1'b0;
        x_ext    = '0;
        prod     = '0;
        q        = '0;
        v_ext    = {{DATA_SIZE{volume_cur[DATA_SIZE-1]}}, volume_cur};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            x_ext = {{DATA_SIZE{x_reg[ch*DATA_SIZE+DATA_SIZE-1]}}, x_reg[ch*DATA_SIZE +: DATA_SIZE]};
            prod  = x_ext * v_ext;
            // Bias negative products so the arithmetic shift truncates toward zero.
            q     = (prod[PW-1] ? prod + ROUND_ADD : prod) >>> BITS;
            if (q > SAT_MAX) begin
                y_next[ch*DATA_SIZE +: DATA_SIZE] = SAT_MAX[DATA_SIZE-1:0];
                any_clip = 1'b1;
            end else if (q < SAT_MIN) begin
                y_next[ch*DATA_SIZE +: DATA_SIZE] = SAT_MIN[DATA_SIZE-1:0];
                any_clip = 1'b1;
            end else begin
                y_next[ch*DATA_SIZE +: DATA_SIZE] = q[DATA_SIZE-1:0];
            end
        end
    end

    always_comb begin
        target_eff = mute ? '0 : volume_target;
        diff       = {target_eff[DATA_SIZE-1], target_eff} - {volume_cur[DATA_SIZE-1], volume_cur};
        mag        = diff[DATA_SIZE] ? $unsigned(-diff) : $unsigned(diff);
        if ((RAMP_STEP == 0) || (mag <= STEP_MAG)) begin
            vol_next = target_eff;
        end else if (diff[DATA_SIZE]) begin
            vol_next = volume_cur - STEP;
        end else begin
            vol_next = volume_cur + STEP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            volume_cur <= '0;
            sat_count  <= '0;
            out_din_r  <= '0;
            // NOTE: x_reg is always overwritten before use; it is reset only to keep simulation free of X.
            x_reg      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.in_empty) begin
                        x_reg <= bus.in_dout;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    out_din_r <= y_next;
                    if (any_clip && (sat_count != 16'hFFFF)) begin
                        sat_count <= sat_count + 16'd1;
                    end
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    // Gain only moves between frames, so a frame never sees two gains.
                    if (!bus.out_full) begin
                        volume_cur <= vol_next;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gain_ramp_multi.sv
// Directed bench for gain_ramp_multi: one instance with RAMP_STEP=0, one with RAMP_STEP=4,
// selected by sel and fed from a shared FWFT source / sink model.
module tb_gain_ramp_multi;
    localparam int DS = 32;
    localparam int CH = 2;
    localparam int FW = DS * CH;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic                 sel;
    logic                 src_empty;
    logic [FW-1:0]        src_dout;
    logic                 snk_full;
    logic signed [DS-1:0] volume_target;
    logic                 mute;

    logic signed [DS-1:0] vol0, vol4, vol;
    logic [15:0]          sat0, sat4, sat;
    logic                 rd_en, wr_en;
    logic [FW-1:0]        dout;

    gain_ramp_multi_if #(.DATA_SIZE(DS), .CHANNELS(CH)) bus0 ();
    gain_ramp_multi_if #(.DATA_SIZE(DS), .CHANNELS(CH)) bus4 ();

    assign bus0.in_empty = sel | src_empty;
    assign bus4.in_empty = !sel | src_empty;
    assign bus0.in_dout  = src_dout;
    assign bus4.in_dout  = src_dout;
    assign bus0.out_full = snk_full;
    assign bus4.out_full = snk_full;

    assign rd_en = sel ? bus4.in_rd_en  : bus0.in_rd_en;
    assign wr_en = sel ? bus4.out_wr_en : bus0.out_wr_en;
    assign dout  = sel ? bus4.out_din   : bus0.out_din;
    assign vol   = sel ? vol4 : vol0;
    assign sat   = sel ? sat4 : sat0;

    gain_ramp_multi #(.DATA_SIZE(DS), .CHANNELS(CH), .BITS(10), .RAMP_STEP(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave), .volume_target(volume_target),
        .mute(mute), .volume_cur(vol0), .sat_count(sat0)
    );

    gain_ramp_multi #(.DATA_SIZE(DS), .CHANNELS(CH), .BITS(10), .RAMP_STEP(4)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4.slave), .volume_target(volume_target),
        .mute(mute), .volume_cur(vol4), .sat_count(sat4)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [FW-1:0] in_q[$];
    logic [FW-1:0] got_q[$];
    logic [FW-1:0] sent_q[$];

    // Drives the FIFO models one cycle at a time until n frames were pushed or the budget runs out.
    task automatic run_stream(input int n, input bit rnd);
        int budget;
        budget = 30 * n + 50;
        got_q.delete();
        while (got_q.size() < n && budget > 0) begin
            @(negedge clock);
            src_empty = (in_q.size() == 0) || (rnd && ($urandom_range(0, 1) == 0));
            src_dout  = (in_q.size() != 0) ? in_q[0] : '0;
            snk_full  = rnd && ($urandom_range(0, 2) == 0);
            #1;
            if (rd_en) void'(in_q.pop_front());
            if (wr_en) got_q.push_back(dout);
            budget--;
        end
        n_total++;
        if (got_q.size() != n) $display("FAIL stream_timeout frames=%0d expected=%0d", got_q.size(), n);
        else n_pass++;
        @(negedge clock);
        src_empty = 1'b1;
        snk_full  = 1'b0;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic send_one(input logic [FW-1:0] f);
        in_q.delete();
        in_q.push_back(f);
        run_stream(1, 1'b0);
    endtask

    task automatic test_reset();
        sel = 1'b0; src_empty = 1'b0; src_dout = 64'h1111_2222_3333_4444;
        reset = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_total++;
            if (rd_en !== 1'b0 || wr_en !== 1'b0) $display("FAIL reset_handshake sel=%0d rd=%b wr=%b expected 0/0", s, rd_en, wr_en);
            else n_pass++;
            n_total++;
            if (vol !== '0 || sat !== '0 || dout !== '0) $display("FAIL reset_state sel=%0d vol=%h sat=%h dout=%h expected zeros", s, vol, sat, dout);
            else n_pass++;
        end
        sel = 1'b0; src_empty = 1'b1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_unity();
        logic [FW-1:0] f;
        sel = 1'b0; volume_target = 32'h400; mute = 1'b0;
        send_one('0);
        in_q.delete(); sent_q.delete();
        for (int i = 0; i < 1000; i++) begin
            f = {$urandom(), $urandom()};
            in_q.push_back(f);
            sent_q.push_back(f);
        end
        run_stream(1000, 1'b0);
        for (int i = 0; i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== sent_q[i]) $display("FAIL unity frame=%0d got=%h expected=%h", i, got_q[i], sent_q[i]);
            else n_pass++;
        end
        n_total++;
        if (sat !== 16'd0) $display("FAIL unity_sat got=%0d expected=0", sat);
        else n_pass++;
    endtask

    task automatic test_truncation();
        sel = 1'b0; volume_target = 32'h200;
        pulse_reset();
        send_one('0);
        n_total++;
        if (got_q[0] !== '0) $display("FAIL trunc_prime got=%h expected=0", got_q[0]);
        else n_pass++;
        send_one({32'h0000_0003, 32'hFFFF_FFFD});
        n_total++;
        if (got_q[0] !== {32'h0000_0001, 32'hFFFF_FFFF}) $display("FAIL trunc got=%h expected=%h", got_q[0], {32'h0000_0001, 32'hFFFF_FFFF});
        else n_pass++;
        send_one({32'hFFFF_FFF9, 32'h8000_0001});
        n_total++;
        if (got_q[0] !== {32'hFFFF_FFFD, 32'hC000_0001}) $display("FAIL trunc_neg got=%h expected=%h", got_q[0], {32'hFFFF_FFFD, 32'hC000_0001});
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [FW-1:0] vin[3];
        logic [FW-1:0] vexp[3];
        logic [15:0]   sexp[3];
        vin  = '{{32'h0, 32'h7FFF_FFFF}, {32'h0, 32'h8000_0000}, {32'h0, 32'h0000_0010}};
        vexp = '{{32'h0, 32'h7FFF_FFFF}, {32'h0, 32'h8000_0000}, {32'h0, 32'h0000_0020}};
        sexp = '{16'd1, 16'd2, 16'd2};
        sel = 1'b0; volume_target = 32'h800;
        pulse_reset();
        send_one('0);
        for (int i = 0; i < 3; i++) begin
            send_one(vin[i]);
            n_total++;
            if (got_q[0] !== vexp[i]) $display("FAIL sat_data step=%0d got=%h expected=%h", i, got_q[0], vexp[i]);
            else n_pass++;
            n_total++;
            if (sat !== sexp[i]) $display("FAIL sat_count step=%0d got=%0d expected=%0d", i, sat, sexp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] a;
        logic [FW-1:0] f;
        a = {32'h1234_5678, 32'hFEDC_BA98};
        sel = 1'b0; volume_target = 32'h400;
        send_one('0);
        @(negedge clock);
        snk_full = 1'b1; src_dout = a; src_empty = 1'b0;
        #1;
        n_total++;
        if (rd_en !== 1'b1) $display("FAIL bp_pop got=%b expected=1", rd_en);
        else n_pass++;
        @(posedge clock);
        @(negedge clock);
        src_dout = ~a;
        @(posedge clock);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #1;
            n_total++;
            if (wr_en !== 1'b0 || rd_en !== 1'b0) $display("FAIL bp_hold cycle=%0d wr=%b rd=%b expected 0/0", c, wr_en, rd_en);
            else n_pass++;
            n_total++;
            if (dout !== a) $display("FAIL bp_data cycle=%0d got=%h expected=%h", c, dout, a);
            else n_pass++;
        end
        @(negedge clock);
        src_empty = 1'b1; snk_full = 1'b0;
        #1;
        n_total++;
        if (wr_en !== 1'b1 || dout !== a) $display("FAIL bp_release wr=%b dout=%h expected 1/%h", wr_en, dout, a);
        else n_pass++;
        @(posedge clock);
        #1;
        n_total++;
        if (wr_en !== 1'b0) $display("FAIL bp_single_push wr=%b expected=0", wr_en);
        else n_pass++;

        in_q.delete(); sent_q.delete();
        for (int i = 0; i < 500; i++) begin
            f = {$urandom(), $urandom()};
            in_q.push_back(f);
            sent_q.push_back(f);
        end
        run_stream(500, 1'b1);
        for (int i = 0; i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== sent_q[i]) $display("FAIL bp_random frame=%0d got=%h expected=%h", i, got_q[i], sent_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ramp();
        logic [DS-1:0] e;
        sel = 1'b1; volume_target = 32'h400; mute = 1'b0;
        pulse_reset();
        in_q.delete();
        for (int i = 0; i < 261; i++) in_q.push_back({32'h0001_0000, 32'h0001_0000});
        run_stream(261, 1'b0);
        for (int k = 0; k < got_q.size(); k++) begin
            e = (k < 256) ? DS'(k * 32'h100) : 32'h0001_0000;
            n_total++;
            if (got_q[k] !== {e, e}) $display("FAIL ramp frame=%0d got=%h expected=%h", k, got_q[k], {e, e});
            else n_pass++;
        end
        n_total++;
        if (vol !== 32'h400) $display("FAIL ramp_final got=%h expected=00000400", vol);
        else n_pass++;
    endtask

    task automatic test_mute();
        logic [DS-1:0] e;
        sel = 1'b1; mute = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            send_one({32'h0001_0000, 32'h0001_0000});
            e = (k <= 256) ? DS'(32'h400 - 4 * k) : '0;
            n_total++;
            if (vol !== e) $display("FAIL mute_ramp frame=%0d got=%h expected=%h", k, vol, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        sel = 1'b1; mute = 1'b0; volume_target = 32'h400;
        in_q.delete();
        in_q.push_back('0);
        in_q.push_back('0);
        run_stream(2, 1'b0);
        @(negedge clock);
        snk_full = 1'b1; src_dout = {32'h0001_0000, 32'h0001_0000}; src_empty = 1'b0;
        @(posedge clock);
        @(negedge clock);
        src_empty = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        n_total++;
        if (dout !== {32'h200, 32'h200} || wr_en !== 1'b0) $display("FAIL rst_pending dout=%h wr=%b expected %h/0", dout, wr_en, {32'h200, 32'h200});
        else n_pass++;
        snk_full = 1'b0;
        #1;
        n_total++;
        if (wr_en !== 1'b1) $display("FAIL rst_pre_wr got=%b expected=1", wr_en);
        else n_pass++;
        reset = 1'b0; src_empty = 1'b0;
        #1;
        n_total++;
        if (wr_en !== 1'b0 || rd_en !== 1'b0) $display("FAIL rst_mid_handshake wr=%b rd=%b expected 0/0", wr_en, rd_en);
        else n_pass++;
        n_total++;
        if (vol !== '0 || dout !== '0 || sat !== '0) $display("FAIL rst_mid_state vol=%h dout=%h sat=%h expected zeros", vol, dout, sat);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1; src_empty = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            #1;
            if (wr_en) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL rst_dropped_frame wr_seen=%b expected=0", seen);
        else n_pass++;
    endtask

    initial begin
        sel = 1'b0; src_empty = 1'b1; src_dout = '0; snk_full = 1'b0;
        volume_target = '0; mute = 1'b0;
        test_reset();
        test_unity();
        test_truncation();
        test_saturate();
        test_backpressure();
        test_ramp();
        test_mute();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
